cpu_check_monitor: RTL and testbench
====================================

Name: cpu_check_monitor

Overview:
- Sits directly downstream of risc_v_cpu and consumes its 32-bit check bus.
- Decodes the self-test completion signature and reports pass, fail or timeout on sticky status outputs.
- Counts cycles and check-value changes so benches and on-board status LEDs can tell that a program has finished and how it ended.
- Synthesizable; used in both the simulation bench and the FPGA top.

Parameters:
- PASS_CODE, 32'h0000_0001, check value that signals a passing test.
- STABLE_CYCLES, 4, consecutive cycles a terminal value must hold before it is accepted (min 1).
- TIMEOUT_CYCLES, 100000, cycles after reset release with no verdict before timeout is flagged (min 1).
- CHG_W, 16, width of the change counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RES  in  1  reset, asynchronous, active-low.
- check  in  32  CPU check bus (risc_v_cpu.check).
- done  out  1  sticky; a verdict (pass, fail or timeout) has been reached.
- pass  out  1  sticky; stable check == PASS_CODE.
- fail  out  1  sticky; stable odd check value other than PASS_CODE.
- timeout  out  1  sticky; no verdict within TIMEOUT_CYCLES.
- fail_test  out  31  check[31:1] captured at the fail verdict.
- cycle_count  out  32  cycles in RUN, saturating at 32'hFFFF_FFFF.
- change_count  out  CHG_W  number of cycles where check differed from the previous cycle, saturating.

Behaviour:
- Reset (RES=0, asynchronous):
  - All outputs and internal registers go to 0.
  - State goes to IDLE.
  - The previous-value register goes to 0.
- check is registered once on entry (chk_q). All decode uses chk_q, giving 1 cycle of input latency.
- State IDLE: entered on reset. The first clock edge with RES=1 moves to RUN.
- State RUN:
  - cycle_count increments every cycle.
  - Change detect: if chk_q != chk_prev, increment change_count, reload the stable counter to 1 and set chk_prev <= chk_q. Otherwise increment the stable counter, saturating at STABLE_CYCLES.
  - A value is terminal if chk_q[0]==1. Even values, including 0, are progress values and never produce a verdict.
  - When the stable counter reaches STABLE_CYCLES on a terminal value:
    - If chk_q == PASS_CODE, go to PASS.
    - Otherwise go to FAIL and capture fail_test <= chk_q[31:1].
  - If cycle_count reaches TIMEOUT_CYCLES-1 with no verdict, go to TMO.
  - If a verdict and the timeout occur in the same cycle, the verdict wins; timeout stays 0.
- States PASS, FAIL, TMO:
  - Terminal. The matching flag and done are asserted in the cycle after the transition and hold until reset.
  - cycle_count freezes.
  - change_count keeps counting, so post-verdict activity stays visible.
- Glitches: a terminal value that changes before STABLE_CYCLES restarts the stability check with no flag. Example: 1 → 3 → 1 requires a fresh full hold of the final 1.
- Verdict latency: a terminal value first seen on check at cycle N raises done at cycle N+1+STABLE_CYCLES.
- Exclusivity: exactly one of pass, fail or timeout is ever 1, and only when done=1.
- Reset mid-operation: RES=0 at any time returns to IDLE and clears all outputs.
- Saturation: counters never wrap.

Optional Feature:
- Macro: CHECK_MON_HIST_EN.
- When defined:
  - Adds output port hist (128 bits).
  - hist is a 4-deep shift register of the last distinct chk_q values, newest in [31:0]. It shifts on every change-detect event in any state except IDLE.
  - Cleared by reset.
- When undefined: the port and its registers are absent; all other behaviour is identical.

Test Plan:
- Pass after progress: hold RES=0 for 5 cycles; check=0, then 2, 4, then 1 held → done=1 and pass=1 exactly STABLE_CYCLES+1 cycles after 1 appears; change_count=3; fail=0; timeout=0.
- Fail with test number: check=32'h0000_000B held → fail=1, fail_test=5, pass=0.
- Glitch rejection: check=1 for 2 cycles, 3 for 1 cycle, then 1 held → no flag before a fresh 4-cycle hold of 1; final verdict pass=1.
- Timeout: TIMEOUT_CYCLES=50, check held at 0 → timeout=1 and done=1 after exactly 50 RUN cycles; cycle_count frozen at 49.
- Reset mid-run: assert RES=0 asynchronously between edges after pass=1 → all outputs read 0 immediately; after release, cycle_count restarts from 0.
- With CHECK_MON_HIST_EN: sequence 2, 4, 6, 8, 1 → hist = {32'h4, 32'h6, 32'h8, 32'h1} (oldest first, newest in [31:0]).

Source files
------------

// File: rtl/cpu_check_monitor.sv
// cpu_check_monitor: decodes the risc_v_cpu self-test signature on check.
// Define CHECK_MON_HIST_EN to add the 128-bit hist output.
module cpu_check_monitor #(
    parameter logic [31:0] PASS_CODE      = 32'h0000_0001,
    parameter int          STABLE_CYCLES  = 4,
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter int          CHG_W          = 16
) (
    input  logic             CLK,
    input  logic             RES,
    input  logic [31:0]      check,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [30:0]      fail_test,
    output logic [31:0]      cycle_count,
    output logic [CHG_W-1:0] change_count
`ifdef CHECK_MON_HIST_EN
    ,
    output logic [127:0]     hist
`endif
);

    localparam int            SW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
    localparam logic [31:0]   TMO_AT   = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        st_idle,
        st_run,
        st_pass,
        st_fail,
        st_tmo
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [31:0]   chk_q;
    logic [31:0]   chk_prev;
    logic [SW-1:0] stab;
    logic [SW-1:0] stab_nx;
    logic          changed;
    logic          verdict;
    logic          active;

    // state register
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) state <= st_idle;
        else      state <= state_nx;
    end

    // stability tracking, next state and status decode
    always_comb begin
        changed  = (chk_q != chk_prev);
        active   = (state != st_idle);
        stab_nx  = stab;
        state_nx = state;
        if (changed)
            stab_nx = SW'(1);
        else if (stab != STAB_MAX)
            stab_nx = stab + 1'b1;
        verdict = chk_q[0] && (stab_nx == STAB_MAX);
        unique case (state)
            st_idle: state_nx = st_run;
            st_run: begin
                if (verdict) begin
                    if (chk_q == PASS_CODE) state_nx = st_pass;
                    else                    state_nx = st_fail;
                end else if (cycle_count == TMO_AT) begin
                    state_nx = st_tmo;
                end
            end
            default: state_nx = state;
        endcase
        pass    = (state == st_pass);
        fail    = (state == st_fail);
        timeout = (state == st_tmo);
        done    = pass | fail | timeout;
    end

    // single input register; all decode works on chk_q
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) chk_q <= '0;
        else      chk_q <= check;
    end

    // change detect, stability count and change counter (live after verdict)
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            chk_prev     <= '0;
            stab         <= '0;
            change_count <= '0;
        end else if (active) begin
            stab <= stab_nx;
            if (changed) begin
                chk_prev <= chk_q;
                if (change_count != {CHG_W{1'b1}})
                    change_count <= change_count + 1'b1;
            end
        end
    end

    // cycle_count indexes RUN cycles and freezes on leaving RUN
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            cycle_count <= '0;
        end else if (state == st_run && state_nx == st_run) begin
            if (cycle_count != 32'hFFFF_FFFF)
                cycle_count <= cycle_count + 32'd1;
        end
    end

    // capture failing test number at the fail verdict
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES)
            fail_test <= '0;
        else if (state == st_run && state_nx == st_fail)
            fail_test <= chk_q[31:1];
    end

`ifdef CHECK_MON_HIST_EN
    // last four distinct check values, newest in the low word
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES)
            hist <= '0;
        else if (active && changed)
            hist <= {hist[95:0], chk_q};
    end
`endif

endmodule

// File: tb/tb_cpu_check_monitor.sv
// tb_cpu_check_monitor: random and directed checks of cpu_check_monitor
// against a stream-level reference model of the completion signature.
module tb_cpu_check_monitor;

    localparam int          S    = 4;
    localparam int          T    = 50;
    localparam int          CW   = 4;
    localparam logic [31:0] PASS = 32'h0000_0001;

    logic          CLK = 1'b0;
    logic          RES = 1'b1;
    logic [31:0]   check = '0;
    logic          done;
    logic          pass;
    logic          fail;
    logic          timeout;
    logic [30:0]   fail_test;
    logic [31:0]   cycle_count;
    logic [CW-1:0] change_count;
`ifdef CHECK_MON_HIST_EN
    logic [127:0]  hist;
    logic [127:0]  e_hist;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0]   seq[$];
    logic          e_done;
    logic          e_pass;
    logic          e_fail;
    logic          e_tmo;
    logic [30:0]   e_ft;
    logic [31:0]   e_cyc;
    logic [CW-1:0] e_chg;

    cpu_check_monitor #(
        .PASS_CODE      (PASS),
        .STABLE_CYCLES  (S),
        .TIMEOUT_CYCLES (T),
        .CHG_W          (CW)
    ) dut (
        .CLK          (CLK),
        .RES          (RES),
        .check        (check),
        .done         (done),
        .pass         (pass),
        .fail         (fail),
        .timeout      (timeout),
        .fail_test    (fail_test),
        .cycle_count  (cycle_count),
        .change_count (change_count)
`ifdef CHECK_MON_HIST_EN
        ,
        .hist         (hist)
`endif
    );

    always #5 CLK = ~CLK;

    // seq[k] is the check value sampled at the k-th edge after reset release;
    // edge 0 leaves IDLE, edge k>=1 evaluates seq[k-1] in RUN.
    task automatic model();
        int n;
        int run;
        int end_k;
        logic [31:0] cur;
        logic [31:0] prv;
        n = seq.size();
        e_pass = 0;
        e_fail = 0;
        e_tmo  = 0;
        e_ft   = '0;
        e_cyc  = '0;
        e_chg  = '0;
`ifdef CHECK_MON_HIST_EN
        e_hist = '0;
`endif
        run   = 0;
        end_k = 0;
        for (int k = 1; k < n; k++) begin
            cur = seq[k-1];
            prv = (k == 1) ? 32'h0 : seq[k-2];
            if (cur != prv) begin
                run = 1;
                if (e_chg != {CW{1'b1}}) e_chg = e_chg + 1'b1;
`ifdef CHECK_MON_HIST_EN
                e_hist = {e_hist[95:0], cur};
`endif
            end else begin
                run = run + 1;
            end
            if (end_k == 0) begin
                if (cur[0] && run == S) begin
                    end_k = k;
                    if (cur == PASS) begin
                        e_pass = 1;
                    end else begin
                        e_fail = 1;
                        e_ft   = cur[31:1];
                    end
                end else if (k == T) begin
                    end_k = k;
                    e_tmo = 1;
                end
            end
        end
        e_done = e_pass | e_fail | e_tmo;
        if (n > 0)
            e_cyc = (end_k != 0) ? 32'(end_k - 1) : 32'(n - 1);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        model();
        chk({tag, ".done"}, done, e_done);
        chk({tag, ".pass"}, pass, e_pass);
        chk({tag, ".fail"}, fail, e_fail);
        chk({tag, ".timeout"}, timeout, e_tmo);
        chk({tag, ".fail_test"}, fail_test, e_ft);
        chk({tag, ".cycle_count"}, cycle_count, e_cyc);
        chk({tag, ".change_count"}, change_count, e_chg);
        chk({tag, ".excl"},
            $onehot0({pass, fail, timeout}) &&
            ((pass | fail | timeout) === done), 1);
`ifdef CHECK_MON_HIST_EN
        chk({tag, ".hist"}, hist, e_hist);
`endif
    endtask

    task automatic step(input string tag, input logic [31:0] v);
        check = v;
        @(posedge CLK);
        if (RES) seq.push_back(v);
        #1;
        check_all(tag);
    endtask

    // asynchronous reset between edges, hold, release away from the edge
    task automatic do_reset(input string tag);
        @(posedge CLK);
        #3;
        RES = 1'b0;
        seq.delete();
        #1;
        check_all(tag);
        repeat (5) @(posedge CLK);
        #2;
        RES = 1'b1;
    endtask

    initial begin
        logic [31:0] v;
        int len;
        int hold;

        #1;
        RES = 1'b0;
        #1;
        check_all("por");

        // pass after progress values
        do_reset("rst1");
        step("p0", 32'h0);
        step("p2", 32'h2);
        step("p4", 32'h4);
        for (int i = 0; i < S; i++) step("p1", PASS);
        chk("pass_early.done", done, 0);
        step("p1", PASS);
        chk("pass_lat.done", done, 1);
        chk("pass_lat.pass", pass, 1);
        chk("pass_lat.chg", change_count, 3);
        chk("pass_lat.fail", fail, 0);
        chk("pass_lat.tmo", timeout, 0);

        // reset mid-run after pass; cycle_count restarts from 0
        do_reset("rst_mid");
        chk("rst_mid.pass", pass, 0);
        chk("rst_mid.cyc", cycle_count, 0);
        step("rr0", 32'h0);
        chk("restart0.cyc", cycle_count, 0);
        step("rr1", 32'h0);
        chk("restart1.cyc", cycle_count, 1);

        // fail with test number, then change_count saturation after verdict
        do_reset("rst2");
        for (int i = 0; i < S + 2; i++) step("f", 32'hB);
        chk("fail.fail", fail, 1);
        chk("fail.test", fail_test, 5);
        chk("fail.pass", pass, 0);
        for (int i = 0; i < 20; i++)
            step("post", (i % 2 == 0) ? 32'h3 : 32'h5);
        chk("sat.chg", change_count, {CW{1'b1}});
        chk("sat.fail", fail, 1);

        // glitch rejection: 1,1,3 then 1 held
        do_reset("rst3");
        step("g", 32'h1);
        step("g", 32'h1);
        step("g", 32'h3);
        for (int i = 0; i < S; i++) begin
            step("g1", 32'h1);
            chk("glitch.nodone", done, 0);
        end
        step("g1", 32'h1);
        chk("glitch.pass", pass, 1);

        // timeout with check held at 0
        do_reset("rst4");
        for (int i = 0; i < T; i++) step("t", 32'h0);
        chk("tmo_early.tmo", timeout, 0);
        step("t", 32'h0);
        chk("tmo.tmo", timeout, 1);
        chk("tmo.done", done, 1);
        chk("tmo.cyc", cycle_count, T - 1);
        step("t", 32'h0);
        chk("tmo_frozen.cyc", cycle_count, T - 1);

`ifdef CHECK_MON_HIST_EN
        do_reset("rst_h");
        step("h", 32'h0);
        step("h", 32'h2);
        step("h", 32'h4);
        step("h", 32'h6);
        step("h", 32'h8);
        step("h", 32'h1);
        step("h", 32'h1);
        chk("hist.val", hist, 128'h00000004_00000006_00000008_00000001);
`endif

        // randomized scenarios against the reference model
        for (int s = 0; s < 8; s++) begin
            do_reset("rrst");
            len = $urandom_range(70, 20);
            while (len > 0) begin
                case ($urandom_range(0, 5))
                    0: v = $urandom() & 32'hFFFF_FFFE;
                    1: v = PASS;
                    2: v = 32'hB;
                    3: v = $urandom() | 32'h1;
                    4: v = 32'h3;
                    default: v = 32'h0;
                endcase
                hold = $urandom_range(1, S + 2);
                for (int i = 0; i < hold && len > 0; i++) begin
                    step("rnd", v);
                    len--;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
